// File: rtl/gray_enc_rr_sched.sv
// Round-robin scheduler sharing one external Gray encoder among NREQ requesters.
// Credits bound in-flight issues plus buffered results, so backpressure never drops a result.
module gray_enc_rr_sched #(
  parameter int NREQ  = 4,
  parameter int MSB   = 7,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREQ-1:0]             i_req,
  input  logic [NREQ*(MSB+1)-1:0]     i_data,
  output logic [NREQ-1:0]             o_gnt,
  output logic                        o_enc_en,
  output logic [MSB:0]                o_enc_data,
  input  logic                        i_enc_vld,
  input  logic [MSB:0]                i_enc_gray,
  output logic                        o_vld,
  output logic [$clog2(NREQ)-1:0]     o_id,
  output logic [MSB:0]                o_gray,
  input  logic                        i_rdy,
  output logic                        o_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int W   = MSB + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic [IDW-1:0] win;
  logic           found;
  logic           grant;

  logic           tag_v  [0:LAT];
  logic [IDW-1:0] tag_id [0:LAT];

  logic [IDW+W-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    fcnt;
  logic             full;
  logic             wr;
  logic             pop;
  logic             missing;
  logic             err_now;

  // Arbitration: scan upward from ptr, first requester found wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    grant = !i_rst && found && (cnt < CW'(DEPTH));
    o_gnt = grant ? (NREQ'(1) << win) : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      o_enc_en   <= 1'b0;
      o_enc_data <= '0;
    end else begin
      o_enc_en <= grant;
      if (grant) begin
        ptr        <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        o_enc_data <= i_data[int'(win)*W +: W];
      end
    end
  end

  // Tag pipeline: stage 0 runs alongside o_enc_en, stage LAT lines up with i_enc_vld
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j <= LAT; j++) begin
        tag_v[j]  <= 1'b0;
        tag_id[j] <= '0;
      end
    end else begin
      tag_v[0]  <= grant;
      tag_id[0] <= win;
      for (int j = 1; j <= LAT; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
    end
  end

  assign full    = (fcnt == CW'(DEPTH));
  assign pop     = o_vld && i_rdy;
  assign wr      = i_enc_vld && tag_v[LAT] && !full;
  assign missing = tag_v[LAT] && !i_enc_vld;
  assign err_now = i_enc_vld != tag_v[LAT];

  // Credit count: a missing result gives its credit back so issue never stalls forever
  always_comb begin
    int c;
    c = int'(cnt) + int'(grant) - int'(pop) - int'(missing);
    if (c < 0) c = 0;
    if (c > DEPTH) c = DEPTH;
    cnt_next = CW'(c);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      o_err <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      fcnt  <= '0;
    end else begin
      cnt   <= cnt_next;
      o_err <= o_err | err_now;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fcnt <= CW'(int'(fcnt) + int'(wr) - int'(pop));
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[wptr] <= {tag_id[LAT], i_enc_gray};
  end

  // Head is zeroed while empty so outputs read 0 out of reset
  assign o_vld  = (fcnt != '0);
  assign o_id   = o_vld ? mem[rptr][IDW+W-1:W] : '0;
  assign o_gray = o_vld ? mem[rptr][W-1:0]     : '0;

endmodule
